uart_in_responder: RTL and testbench

// - Simulation-side responder for the DUT's UART input port (io_uart_in_valid / io_uart_in_ch), the

---
 rtl/uart_sim_pkg.sv | 16 +
 rtl/uart_char_fifo.sv | 76 +++++++
 rtl/uart_in_responder.sv | 79 +++++++
 tb/tb_uart_in_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_sim_pkg.sv
// Shared types and helpers for the simulation-side UART responder.
package uart_sim_pkg;

  localparam int unsigned UART_CH_W = 8;

  typedef logic [UART_CH_W-1:0] uart_ch_t;
  typedef logic [31:0]          uart_cnt_t;

  localparam uart_ch_t UART_EMPTY_CH = 8'hff;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic uart_cnt_t sat_inc(input uart_cnt_t c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

endpackage

// File: rtl/uart_char_fifo.sv
// DEPTH-entry register-array character FIFO with flush; head is read combinationally.
module uart_char_fifo
  import uart_sim_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  uart_ch_t                     wr_ch,
  input  logic                         pop,
  input  logic                         flush,
  output uart_ch_t                     head,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  uart_ch_t             mem_q [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]     level_q,  level_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only visible when level is nonzero.
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_ch;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (level_q <= LVL_W'(DEPTH)) else $error("fifo level above DEPTH");
      assert (!(push && full))          else $error("fifo push while full");
      assert (!(pop && empty))          else $error("fifo pop while empty");
    end
  end

endmodule

// File: rtl/uart_in_responder.sv
// Answers DUT getc requests from a host-filled FIFO, with optional pacing gap and statistics.
module uart_in_responder
  import uart_sim_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned MIN_GAP  = 0,
  parameter uart_ch_t    EMPTY_CH = UART_EMPTY_CH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  uart_ch_t                    host_ch,
  input  logic                        flush,
  input  logic                        io_uart_in_valid,
  output uart_ch_t                    io_uart_in_ch,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic                        gap_busy,
  output uart_cnt_t                   delivered_cnt,
  output uart_cnt_t                   underflow_cnt
);

  localparam int unsigned GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP+1) : 1;

  logic             push_c, pop_c, deliverable_c;
  logic             fifo_full, fifo_empty;
  uart_ch_t         fifo_head;
  logic [GAP_W-1:0] gap_q, gap_d;
  uart_cnt_t        delivered_q, delivered_d;
  uart_cnt_t        underflow_q, underflow_d;

  uart_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_c),
    .wr_ch   (host_ch),
    .pop     (pop_c),
    .flush   (flush),
    .head    (fifo_head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign deliverable_c = !fifo_empty && (gap_q == '0);
  assign host_ready    = !fifo_full && !flush;
  assign push_c        = host_valid && host_ready;
  assign pop_c         = io_uart_in_valid && deliverable_c && !flush;
  assign io_uart_in_ch = deliverable_c ? fifo_head : EMPTY_CH;

  // Gap reload on delivery wins over decrement; flush clears any gap in progress.
  always_comb begin
    gap_d       = gap_q;
    delivered_d = delivered_q;
    underflow_d = underflow_q;
    if (flush)               gap_d = '0;
    else if (pop_c)          gap_d = GAP_W'(MIN_GAP);
    else if (gap_q != '0)    gap_d = gap_q - GAP_W'(1);
    if (pop_c)                                   delivered_d = sat_inc(delivered_q);
    if (io_uart_in_valid && !deliverable_c)      underflow_d = sat_inc(underflow_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gap_q       <= '0;
      delivered_q <= '0;
      underflow_q <= '0;
    end else begin
      gap_q       <= gap_d;
      delivered_q <= delivered_d;
      underflow_q <= underflow_d;
    end
  end

  assign gap_busy      = (gap_q != '0);
  assign delivered_cnt = delivered_q;
  assign underflow_cnt = underflow_q;

endmodule

// File: tb/tb_uart_in_responder.sv
// Scoreboard bench for uart_in_responder: unpaced (MIN_GAP 0) and paced (MIN_GAP 3) instances.
module tb_uart_in_responder;
  import uart_sim_pkg::*;

  logic      clock = 1'b0;
  logic      reset_n = 1'b0;
  logic      host_valid = 1'b0;
  uart_ch_t  host_ch = '0;
  logic      flush = 1'b0;
  logic      req = 1'b0;

  logic      rdy0, rdy3, busy0, busy3;
  uart_ch_t  ch0, ch3;
  logic [4:0] lvl0, lvl3;
  uart_cnt_t del0, del3, und0, und3;

  int checks = 0;
  int errors = 0;
  uart_ch_t exp_q[$];
  uart_ch_t gap_exp[$];
  logic     busy_exp[$];

  always #5 clock = ~clock;

  uart_in_responder #(.DEPTH(16), .MIN_GAP(0)) dut (
    .clock(clock), .reset_n(reset_n), .host_valid(host_valid), .host_ready(rdy0),
    .host_ch(host_ch), .flush(flush), .io_uart_in_valid(req), .io_uart_in_ch(ch0),
    .level(lvl0), .gap_busy(busy0), .delivered_cnt(del0), .underflow_cnt(und0));

  uart_in_responder #(.DEPTH(16), .MIN_GAP(3)) dut_gap (
    .clock(clock), .reset_n(reset_n), .host_valid(host_valid), .host_ready(rdy3),
    .host_ch(host_ch), .flush(flush), .io_uart_in_valid(req), .io_uart_in_ch(ch3),
    .level(lvl3), .gap_busy(busy3), .delivered_cnt(del3), .underflow_cnt(und3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    exp_q.delete();
    step();
  endtask

  // Push one character into the unpaced instance's model if it should be accepted.
  task automatic push_ch(input uart_ch_t c);
    logic acc;
    host_valid = 1'b1;
    host_ch    = c;
    #1;
    acc = (exp_q.size() < 16);
    chk("host_ready", 32'(rdy0), 32'(acc));
    step();
    host_valid = 1'b0;
    if (acc) exp_q.push_back(c);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_level", 32'(lvl0), 32'd0);
    chk("rst_gap_busy", 32'(busy0), 32'd0);
    chk("rst_host_ready", 32'(rdy0), 32'd1);
    chk("rst_ch", 32'(ch0), 32'hff);
    chk("rst_delivered", del0, 32'd0);
    step();

    // Requests with nothing buffered return EMPTY_CH and count as underflow.
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("empty_ch", 32'(ch0), 32'hff);
      step();
    end
    req = 1'b0;
    chk("t1_underflow", und0, 32'd3);
    chk("t1_delivered", del0, 32'd0);

    // Unpaced back-to-back delivery.
    do_reset();
    push_ch(8'h41);
    push_ch(8'h42);
    chk("t2_level", 32'(lvl0), 32'd2);
    req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_ch", 32'(ch0), 32'(exp_q.pop_front()));
      step();
      chk("t2_level", 32'(lvl0), 32'(exp_q.size()));
    end
    req = 1'b0;
    chk("t2_delivered", del0, 32'd2);

    // Paced instance: one delivery, three gap cycles, then the next character.
    do_reset();
    push_ch(8'h41);
    push_ch(8'h42);
    gap_exp  = '{8'h41, 8'hff, 8'hff, 8'hff, 8'h42};
    busy_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_ch", 32'(ch3), 32'(gap_exp.pop_front()));
      chk("t3_gap_busy", 32'(busy3), 32'(busy_exp.pop_front()));
      step();
    end
    req = 1'b0;
    chk("t3_underflow", und3, 32'd3);
    chk("t3_delivered", del3, 32'd2);

    // Fill to DEPTH, overflow attempt, then simultaneous push/pop.
    do_reset();
    for (int i = 0; i < 17; i++) push_ch(8'h30 + 8'(i));
    chk("t4_level_full", 32'(lvl0), 32'd16);
    host_valid = 1'b1;
    host_ch    = 8'h40;
    req        = 1'b1;
    #1;
    chk("t4_ready_full", 32'(rdy0), 32'd0);
    chk("t4_ch_full", 32'(ch0), 32'(exp_q.pop_front()));
    step();
    chk("t4_level_15", 32'(lvl0), 32'd15);
    #1;
    chk("t4_ready_15", 32'(rdy0), 32'd1);
    chk("t4_ch_pushpop", 32'(ch0), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h40);
    step();
    host_valid = 1'b0;
    chk("t4_level_pushpop", 32'(lvl0), 32'd15);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      #1;
      chk("t4_drain", 32'(ch0), 32'(exp_q.pop_front()));
      step();
    end
    req = 1'b0;
    chk("t4_drained", 32'(lvl0), 32'd0);
    chk("t4_delivered", del0, 32'd17);

    // Flush with a request in the same cycle: no pop, head still visible.
    do_reset();
    for (int i = 0; i < 5; i++) push_ch(8'h61 + 8'(i));
    flush = 1'b1;
    req   = 1'b1;
    #1;
    chk("t5_ch_preflush", 32'(ch0), 32'(exp_q[0]));
    chk("t5_ready_flush", 32'(rdy0), 32'd0);
    step();
    flush = 1'b0;
    exp_q.delete();
    chk("t5_level", 32'(lvl0), 32'd0);
    #1;
    chk("t5_ch_after", 32'(ch0), 32'hff);
    step();
    req = 1'b0;
    chk("t5_delivered", del0, 32'd0);

    // Asynchronous reset mid-cycle clears everything at once.
    do_reset();
    for (int i = 0; i < 4; i++) push_ch(8'h71 + 8'(i));
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("t6_pre_delivered", del0, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_level", 32'(lvl0), 32'd0);
    chk("t6_delivered", del0, 32'd0);
    chk("t6_underflow", und0, 32'd0);
    chk("t6_ch", 32'(ch0), 32'hff);
    chk("t6_host_ready", 32'(rdy0), 32'd1);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
